debounce_sync: RTL and testbench



---
 rtl/debounce_sync.sv | 168 ++++++++++++++++
 tb/tb_debounce_sync.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// debounce_sync
//
// Conditions a raw, asynchronous, bouncy switch/button level for use inside
// the clk domain. It uses a two-flop synchroniser, then a stability counter
// with a four-state FSM. The clean level on dout only changes after
// STABLE_CNT consecutive synchronised samples of the new level.
//
// Parameters
//   STABLE_CNT : consecutive samples needed to accept a new level
//                (legal range 2 .. 2**CNT_W-1)
//   CNT_W      : width of the stability counter
//
// Ports
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset
//   din  : raw asynchronous input level
//   dout : debounced level
//   rise : one-cycle pulse when dout goes 0->1
//   fall : one-cycle pulse when dout goes 1->0
//   busy : high while a candidate level change is being qualified
//
// Configuration macro
//   DEBOUNCE_EDGE_EN : when defined, the rise/fall pulse registers are built.
//                      When undefined, rise and fall are tied to 0.
//                      dout, busy and the latency are the same in both builds.
// -----------------------------------------------------------------------------
module debounce_sync #(
   parameter int unsigned STABLE_CNT = 1000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      ST_LO     = 2'd0,
      ST_CHK_HI = 2'd1,
      ST_HI     = 2'd2,
      ST_CHK_LO = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q;
   logic             s2_q;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             dout_q;
   logic             busy_q;
   logic             cnt_done;
   logic             commit_hi;
   logic             commit_lo;

   assign cnt_d    = cnt_q + CNT_ONE;
   assign cnt_done = (cnt_q == CNT_LAST);

   // The current s2 sample is the STABLE_CNT-th consecutive one at the
   // candidate level. This is the edge at which dout flips.
   assign commit_hi = (state_q == ST_CHK_HI) && s2_q && cnt_done;
   assign commit_lo = (state_q == ST_CHK_LO) && !s2_q && cnt_done;

   // NOTE: every register below is updated with non-blocking assignments so
   // that s2_q <= s1_q reads the old s1_q value and the synchroniser really is
   // two flops deep. A blocking assignment would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
         case (state_q)
            ST_LO: begin
               if (s2_q) begin
                  state_q <= ST_CHK_HI;
                  cnt_q   <= CNT_ONE;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q   <= '0;
               end
            end
            ST_CHK_HI: begin
               if (!s2_q) begin
                  // Bounce back: discard progress, dout untouched.
                  state_q <= ST_LO;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (commit_hi) begin
                  state_q <= ST_HI;
                  dout_q  <= 1'b1;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_d;
               end
            end
            ST_HI: begin
               if (!s2_q) begin
                  state_q <= ST_CHK_LO;
                  cnt_q   <= CNT_ONE;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q   <= '0;
               end
            end
            ST_CHK_LO: begin
               if (s2_q) begin
                  state_q <= ST_HI;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (commit_lo) begin
                  state_q <= ST_LO;
                  dout_q  <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_d;
               end
            end
            default: begin
               state_q <= ST_LO;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dout = dout_q;
   assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q;
   logic fall_q;

   // The commits are mutually exclusive because they come from different
   // states. This means the two pulses can never be high together.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= commit_hi;
         fall_q <= commit_lo;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Self-checking bench for debounce_sync with STABLE_CNT=4, CNT_W=3.
// A window-based reference model is checked against the DUT on every falling
// edge. In the model, dout flips once the last STABLE_CNT synchronised
// samples all differ from it. Directed scenarios pin latencies, busy lengths
// and pulse counts with literal values. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

   localparam int N  = 4;
   localparam int CW = 3;
`ifdef DEBOUNCE_EDGE_EN
   localparam logic EDGE_EN = 1'b1;
`else
   localparam logic EDGE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic din;
   logic dout;
   logic rise;
   logic fall;
   logic busy;

   always #5 clk = ~clk;

   debounce_sync #(
      .STABLE_CNT (N),
      .CNT_W      (CW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .dout (dout),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic         m_s1   = 1'b0;
   logic         m_s2   = 1'b0;
   logic [N-1:0] m_hist = '0;   // last N FSM samples, newest in bit 0
   logic         m_dout = 1'b0;
   logic         m_rise = 1'b0;
   logic         m_fall = 1'b0;
   logic         m_busy = 1'b0;
   logic         cmp_en = 1'b0;

   always @(posedge clk) begin
      logic sample;
      logic all_diff;
      if (rst) begin
         m_s1   = 1'b0;
         m_s2   = 1'b0;
         m_hist = '0;
         m_dout = 1'b0;
         m_rise = 1'b0;
         m_fall = 1'b0;
         m_busy = 1'b0;
      end else begin
         sample   = m_s2;
         m_s2     = m_s1;
         m_s1     = din;
         m_hist   = {m_hist[N-2:0], sample};
         all_diff = m_dout ? (m_hist == '0) : (&m_hist);
         m_rise   = all_diff && !m_dout;
         m_fall   = all_diff && m_dout;
         if (all_diff) m_dout = ~m_dout;
         m_busy   = (sample != m_dout);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("dout", 32'(dout), 32'(m_dout));
         check("rise", 32'(rise), 32'(m_rise & EDGE_EN));
         check("fall", 32'(fall), 32'(m_fall & EDGE_EN));
         check("busy", 32'(busy), 32'(m_busy));
         check("rise_fall_excl", 32'(rise & fall), 32'd0);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive din to lvl, then watch up to 12 edges. Report the edge count at
   // which dout first equals lvl (0 means it never did), the number of busy
   // cycles, and the number of matching pulses.
   task automatic measure(input logic lvl, output int lat, output int busy_cyc, output int pulses);
      lat = 0; busy_cyc = 0; pulses = 0;
      din = lvl;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         if (dout == lvl && lat == 0) lat = i;
         busy_cyc += int'(busy);
         pulses   += int'(lvl ? rise : fall);
      end
   endtask

   initial begin
      int lat, bcyc, pls;
      logic dout_seen, busy_seen;
      int pulse_cnt;

      // Scenario 1: reset held with din=1, then released
      rst = 1'b1;
      din = 1'b1;
      step(1);
      cmp_en = 1'b1;
      step(1);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_rise", 32'(rise), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step(5);
      check("s1_dout_before", 32'(dout), 32'd0);
      check("s1_busy_mid", 32'(busy), 32'd1);
      step(1);
      check("s1_dout_after", 32'(dout), 32'd1);
      check("s1_rise", 32'(rise), 32'(EDGE_EN));
      step(1);
      check("s1_rise_gone", 32'(rise), 32'd0);

      // Scenario 2: clean release and press
      step(14);
      measure(1'b0, lat, bcyc, pls);
      check("s2_fall_latency", 32'(lat), 32'd6);
      check("s2_fall_busy", 32'(bcyc), 32'd3);
      check("s2_fall_pulses", 32'(pls), 32'(EDGE_EN));
      measure(1'b1, lat, bcyc, pls);
      check("s2_rise_latency", 32'(lat), 32'd6);
      check("s2_rise_busy", 32'(bcyc), 32'd3);
      check("s2_rise_pulses", 32'(pls), 32'(EDGE_EN));
      step(8);
      measure(1'b0, lat, bcyc, pls);
      check("s2_fall2_latency", 32'(lat), 32'd6);

      // Scenario 3: bounce 1,0,1,0 (2 cycles each), then settle at 0
      dout_seen = 1'b0; busy_seen = 1'b0; pulse_cnt = 0;
      for (int k = 0; k < 24; k++) begin
         din = (k < 8) ? ((k / 2) % 2 == 0) : 1'b0;
         step(1);
         dout_seen |= dout;
         busy_seen |= busy;
         pulse_cnt += int'(rise) + int'(fall);
      end
      check("s3_dout_stays_0", 32'(dout_seen), 32'd0);
      check("s3_no_pulses", 32'(pulse_cnt), 32'd0);
      check("s3_busy_pulsed", 32'(busy_seen), 32'd1);
      check("s3_busy_idle", 32'(busy), 32'd0);

      // Scenario 4: reset while busy with cnt=2, din kept high
      din = 1'b1;
      step(4);
      check("s4_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      step(1);
      check("s4_rst_busy", 32'(busy), 32'd0);
      check("s4_rst_dout", 32'(dout), 32'd0);
      rst = 1'b0;
      measure(1'b1, lat, bcyc, pls);
      check("s4_full_latency", 32'(lat), 32'd6);
      check("s4_busy", 32'(bcyc), 32'd3);
      measure(1'b0, lat, bcyc, pls);

      // Scenario 6: exactly 3 samples high is rejected, 4 samples is accepted
      dout_seen = 1'b0;
      din = 1'b1;
      step(3);
      din = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step(1);
         dout_seen |= dout;
      end
      check("s6_three_rejected", 32'(dout_seen), 32'd0);
      dout_seen = 1'b0; pulse_cnt = 0;
      din = 1'b1;
      step(4);
      din = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step(1);
         dout_seen |= dout;
         pulse_cnt += int'(rise);
      end
      check("s6_four_accepted", 32'(dout_seen), 32'd1);
      check("s6_four_rise", 32'(pulse_cnt), 32'(EDGE_EN));
      step(12);

      // Randomized phase: runs of random length with occasional resets
      for (int it = 0; it < 800; it++) begin
         din = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
         end
         step($urandom_range(1, 7));
      end
      din = 1'b0;
      step(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
